// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt controller.
package irq_pkg;

    localparam int unsigned DEFAULT_NUM_IRQ    = 3;
    localparam logic [31:0] DEFAULT_VEC_BASE   = 32'h0000_0000;
    localparam int unsigned DEFAULT_VEC_STRIDE = 4;

    // Channel-id width: max(1, clog2(n)).
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: index of the highest set bit plus a valid flag.
module irq_prio_enc #(
    parameter int unsigned N    = 3,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    bits,
    output logic            valid,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (bits[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Nested, fixed-priority interrupt controller with edge-triggered request lines.
// Optional per-channel mask register enabled by defining IRQ_MASK_EN.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned       NUM_IRQ    = DEFAULT_NUM_IRQ,
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  VEC_BASE   = WIDTH'(DEFAULT_VEC_BASE),
    parameter int unsigned       VEC_STRIDE = DEFAULT_VEC_STRIDE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IRQ-1:0]              IRQ,
    input  logic                            ie,
    input  logic                            ack,
    input  logic                            eret,
`ifdef IRQ_MASK_EN
    input  logic                            mask_we,
    input  logic [NUM_IRQ-1:0]              mask_wdata,
`endif
    output logic                            int_req,
    output logic [id_width(NUM_IRQ)-1:0]    int_id,
    output logic [WIDTH-1:0]                int_vec,
    output logic [NUM_IRQ-1:0]              IRW
);

    localparam int unsigned ID_W = id_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] sync0, sync1, hist;
    logic [NUM_IRQ-1:0] pending, isr, mask;
    logic [NUM_IRQ-1:0] rise, eligible, accept_oh, top_isr_oh;
    logic [NUM_IRQ-1:0] pending_next, isr_next;
    logic               pend_valid, isr_valid, accept;
    logic [ID_W-1:0]    pend_id, isr_id;

`ifdef IRQ_MASK_EN
    // Mask resets to all-enabled; masked channels still latch pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
        end else if (mask_we) begin
            mask <= mask_wdata;
        end
    end
`else
    assign mask = '1;
`endif

    assign rise     = sync1 & ~hist;
    assign eligible = pending & mask;

    irq_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_pend_enc (
        .bits  (eligible),
        .valid (pend_valid),
        .idx   (pend_id)
    );

    irq_prio_enc #(.N(NUM_IRQ), .ID_W(ID_W)) u_isr_enc (
        .bits  (isr),
        .valid (isr_valid),
        .idx   (isr_id)
    );

    // Request only when the best pending channel strictly outranks the active handler.
    assign int_req = ie & pend_valid & (~isr_valid | (pend_id > isr_id));
    assign int_id  = pend_id;
    assign int_vec = VEC_BASE + WIDTH'(pend_id) * WIDTH'(VEC_STRIDE);
    assign IRW     = isr;

    always_comb begin
        accept       = ack & int_req;
        accept_oh    = '0;
        top_isr_oh   = '0;
        if (accept) begin
            accept_oh = NUM_IRQ'(1) << pend_id;
        end
        if (eret && isr_valid) begin
            top_isr_oh = NUM_IRQ'(1) << isr_id;
        end
        // A fresh edge in the ack cycle re-arms the channel.
        pending_next = (pending & ~accept_oh) | rise;
        isr_next     = (isr & ~top_isr_oh) | accept_oh;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0   <= '0;
            sync1   <= '0;
            hist    <= '0;
            pending <= '0;
            isr     <= '0;
        end else begin
            sync0   <= IRQ;
            sync1   <= sync0;
            hist    <= sync1;
            pending <= pending_next;
            isr     <= isr_next;
        end
    end

endmodule
